// File: rtl/bist_pkg.sv
// Shared definitions for the memory-BIST controller, datapath and bench.
// Holds the geometry defaults, the depth derivation and the march element encoding.
package bist_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int WIDTH_DEF  = 8;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef enum logic [1:0] {
    MARCH_W0 = 2'd0,
    MARCH_R0 = 2'd1,
    MARCH_W1 = 2'd2,
    MARCH_R1 = 2'd3
  } march_op_e;

endpackage

// File: rtl/bist_addr_counter.sv
// Up/down address counter for the BIST datapath; wraps modulo DEPTH and
// flags the terminal count of the current direction on carry.
module bist_addr_counter
  import bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  output logic [ADDR_W-1:0] addr,
  output logic              carry
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Sync clear beats preset, preset beats stepping.
  always_comb begin
    addr_d = addr_q;
    if (reset)       addr_d = '0;
    else if (preset) addr_d = '1;
    else if (en)     addr_d = up_down ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr  = addr_q;
  assign carry = up_down ? (addr_q == '1) : (addr_q == '0);

endmodule

// File: rtl/bist_mem_datapath.sv
// Responder side of the memory-BIST interface: address counter, RAM under test,
// one-cycle read-compare pipeline and a stuck-at fault injector on both RAM paths.
module bist_mem_datapath
  import bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  reset,
  input  logic                                  preset,
  input  logic                                  en,
  input  logic                                  up_down,
  input  logic                                  read,
  input  logic                                  write,
  input  logic                                  data,
  output logic                                  carry,
  output logic                                  is_equal,
  output logic [ADDR_W-1:0]                     addr,
  input  logic                                  fi_en,
  input  logic [ADDR_W-1:0]                     fi_addr,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] fi_bit,
  input  logic                                  fi_val
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q, rd_d, exp_q, exp_d;
  logic [WIDTH-1:0] bg_word, wr_word, cell_word;
  logic             cmp_valid_q, cmp_valid_d;
  logic             fi_hit, do_read;

  bist_addr_counter #(.ADDR_W(ADDR_W)) u_addr_counter (
    .clk     (clk),
    .rst     (rst),
    .reset   (reset),
    .preset  (preset),
    .en      (en),
    .up_down (up_down),
    .addr    (addr),
    .carry   (carry)
  );

  // The stuck bit is forced on the read path too, so cells written before
  // fi_en rose still present the hard fault.
  always_comb begin
    bg_word   = {WIDTH{data}};
    fi_hit    = fi_en && (addr == fi_addr);
    wr_word   = bg_word;
    cell_word = mem_q[addr];
    if (fi_hit) begin
      wr_word[fi_bit]   = fi_val;
      cell_word[fi_bit] = fi_val;
    end
    do_read     = read && !write;
    cmp_valid_d = do_read;
    rd_d        = do_read ? cell_word : rd_q;
    exp_d       = do_read ? bg_word : exp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      rd_q        <= '0;
      exp_q       <= '0;
    end else begin
      cmp_valid_q <= cmp_valid_d;
      rd_q        <= rd_d;
      exp_q       <= exp_d;
    end
  end

  // RAM contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (write) mem_q[addr] <= wr_word;
  end

  assign is_equal = !cmp_valid_q || (rd_q == exp_q);

endmodule

// File: tb/tb_bist_mem_datapath.sv
// Scoreboard bench for bist_mem_datapath: directed march/corner sequences plus a
// random phase, checked against an integer-array model of the memory and counter.
module tb_bist_mem_datapath;
  import bist_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reset = 1'b0, preset = 1'b0, en = 1'b0, up_down = 1'b0;
  logic       read = 1'b0, write = 1'b0, data = 1'b0;
  logic       carry, is_equal;
  logic [3:0] addr;
  logic       fi_en = 1'b0;
  logic [3:0] fi_addr = 4'd0;
  logic [2:0] fi_bit = 3'd0;
  logic       fi_val = 1'b0;

  bist_mem_datapath #(.ADDR_W(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en),
    .up_down(up_down), .read(read), .write(write), .data(data),
    .carry(carry), .is_equal(is_equal), .addr(addr),
    .fi_en(fi_en), .fi_addr(fi_addr), .fi_bit(fi_bit), .fi_val(fi_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    bit c;
    bit eq;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   neq_seen = 0;

  // Reference model state
  int mem_m [16];
  int addr_m = 0;
  bit pend_m = 0;
  bit eq_m = 1;
  int fen_m = 0, faddr_m = 0, fbit_m = 0, fval_m = 0;

  function automatic int apply_fault(int word, int a);
    if (fen_m != 0 && a == faddr_m)
      word = (fval_m != 0) ? (word | (1 << fbit_m)) : (word & ~(1 << fbit_m));
    return word & 255;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (is_equal === 1'b0) neq_seen++;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (addr !== 4'(e.a)) begin
        bad++;
        $display("FAIL addr: got %0d want %0d at %0t", addr, e.a, $time);
      end
      total++;
      if (carry !== e.c) begin
        bad++;
        $display("FAIL carry: got %b want %b (addr %0d) at %0t", carry, e.c, e.a, $time);
      end
      total++;
      if (is_equal !== e.eq) begin
        bad++;
        $display("FAIL is_equal: got %b want %b (addr %0d) at %0t", is_equal, e.eq, e.a, $time);
      end
    end
  end

  task automatic set_fault(input int fe, input int fa, input int fb, input int fv);
    fen_m = fe; faddr_m = fa; fbit_m = fb; fval_m = fv;
  endtask

  // One clock of stimulus: drive just after the edge, record what should be
  // visible during this cycle, then advance the model across the next edge.
  task automatic step(input bit r, input bit rs, input bit ps, input bit e,
                      input bit ud, input bit rd, input bit wr, input bit d);
    exp_t x;
    int bg;
    @(posedge clk);
    #1;
    rst = r; reset = rs; preset = ps; en = e; up_down = ud;
    read = rd; write = wr; data = d;
    fi_en = 1'(fen_m); fi_addr = 4'(faddr_m); fi_bit = 3'(fbit_m); fi_val = 1'(fval_m);
    if (r) begin
      addr_m = 0;
      pend_m = 0;
    end
    x.a  = addr_m;
    x.c  = ud ? (addr_m == 15) : (addr_m == 0);
    x.eq = pend_m ? eq_m : 1'b1;
    q.push_back(x);
    if (!r) begin
      bg = d ? 255 : 0;
      pend_m = rd && !wr;
      if (pend_m) eq_m = (apply_fault(mem_m[addr_m], addr_m) == bg);
      if (wr) mem_m[addr_m] = apply_fault(bg, addr_m);
      if (rs)      addr_m = 0;
      else if (ps) addr_m = 15;
      else if (e)  addr_m = ud ? (addr_m + 1) % 16 : (addr_m + 15) % 16;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One march element over all 16 cells in the given direction.
  task automatic march_elem(input march_op_e op, input bit up);
    bit is_wr, d;
    is_wr = (op == MARCH_W0) || (op == MARCH_W1);
    d     = (op == MARCH_W1) || (op == MARCH_R1);
    if (up) step(0, 1, 0, 0, 1, 0, 0, 0);
    else    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, up, !is_wr, is_wr, d);
  endtask

  task automatic full_march();
    march_elem(MARCH_W0, 1);
    march_elem(MARCH_R0, 0);
    march_elem(MARCH_W1, 1);
    march_elem(MARCH_R1, 1);
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);

    // Counter walk up with wrap
    step(0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // Preset, down walk with wrap, preset+reset priority
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Clean march
    n0 = neq_seen;
    full_march();
    total++;
    if (neq_seen - n0 != 0) begin
      bad++;
      $display("FAIL clean_march_mismatches: got %0d want 0", neq_seen - n0);
    end

    // Stuck-at-1 at addr 5 bit 3: exactly one mismatch (r0 at addr 5)
    set_fault(1, 5, 3, 1);
    n0 = neq_seen;
    full_march();
    total++;
    if (neq_seen - n0 != 1) begin
      bad++;
      $display("FAIL stuck_at_mismatch_count: got %0d want 1", neq_seen - n0);
    end
    set_fault(0, 0, 0, 0);

    // Read/write collision at addr 2, then a real read
    step(0, 1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    idle();

    // Reset mid-compare at addr 7 (holds 0xFF, read expecting 0x00)
    step(0, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    idle();

    // Random traffic with random fault settings
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_fault(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
      step(0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)));
    end
    set_fault(0, 0, 0, 0);
    idle();
    idle();

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
